// File: rtl/playback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : playback_pkg
//  Description : Shared types and constants for the playback replay engine.
//                Provides the default vector widths for one SPARC core
//                stimulus record, the session state encoding and a
//                saturating 16-bit increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package playback_pkg;

  // Default widths: input vector (grant, data_rdy, cpx data, cken, resets)
  // and output vector (pcx req, atom, data).
  localparam int DEF_IN_W  = 157;
  localparam int DEF_OUT_W = 130;
  localparam int DEF_REC_W = DEF_IN_W + DEF_OUT_W;

  localparam logic [15:0] SAT16_MAX = 16'hFFFF;

  // Sentinel for "no mismatch recorded yet".
  localparam logic [31:0] IDX_NONE  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == SAT16_MAX) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/playback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : playback_fifo
//  Description : Synchronous FIFO with pointer wrap tracked by an extra MSB.
//                Push while full and pop while empty are ignored.
//  Ports       : clk, rst (async active-high), clr (sync flush),
//                push/wdata, pop/rdata (show-ahead), full, empty, count.
//  Revision    : 1.0 - initial release
// ============================================================================
module playback_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Equal indices with differing wrap bits means the write pointer has
  // lapped the read pointer exactly once.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/playback_replay.sv
`default_nettype none
// ============================================================================
//  Module      : playback_replay
//  Description : Replay engine for captured per-gclk SPARC core stimulus.
//                Buffers {in_vec, exp_out} records, applies one in_vec per
//                cycle to the core under test, compares the core output with
//                the expected vector one cycle later, and keeps mismatch and
//                underrun accounting.
//  Ports       : clk, rst (async active-high), start (session pulse)
//                in_valid/in_ready/in_data/in_last : record stream
//                cmp_mask                          : compared output bits
//                dut_in/dut_cken/dut_out           : core under test
//                busy/done/fail                    : session status
//                vec_count, mismatch_count, first_mismatch_idx,
//                underrun_count                    : statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module playback_replay
  import playback_pkg::*;
#(
  parameter int IN_W             = DEF_IN_W,
  parameter int OUT_W            = DEF_OUT_W,
  parameter int DEPTH            = 16,
  parameter int PREFILL          = 8,
  parameter int STOP_ON_MISMATCH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W+OUT_W-1:0]  in_data,
  input  logic                   in_last,
  input  logic [OUT_W-1:0]       cmp_mask,
  output logic [IN_W-1:0]        dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  output logic                   dut_cken,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [31:0]            vec_count,
  output logic [15:0]            mismatch_count,
  output logic [31:0]            first_mismatch_idx,
  output logic [15:0]            underrun_count
);

  localparam int REC_W = IN_W + OUT_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] PREFILL_CNT = CW'(PREFILL);

  state_e           state_q, state_d;
  logic             last_seen_q, last_seen_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             dut_cken_q, dut_cken_d;
  logic [31:0]      vec_count_q, vec_count_d;
  logic [15:0]      mismatch_count_q, mismatch_count_d;
  logic [31:0]      first_mismatch_idx_q, first_mismatch_idx_d;
  logic [15:0]      underrun_count_q, underrun_count_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [REC_W-1:0] fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clr;

  logic             busy_w;
  logic             start_ok;
  logic             mism;
  logic             stop_now;

  assign busy_w    = (state_q == ST_PREFILL) || (state_q == ST_RUN);
  // in_ready looks only at the registered occupancy, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign in_ready  = busy_w && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign start_ok  = start && !busy_w;
  assign fifo_clr  = start_ok;

  assign mism      = cmp_valid_q && (|((dut_out ^ exp_q) & cmp_mask));
  assign stop_now  = (STOP_ON_MISMATCH != 0) && mism;
  // A stop-on-mismatch compare freezes the record stream in that same cycle.
  assign fifo_pop  = (state_q == ST_RUN) && !fifo_empty && !stop_now;

  playback_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d              = state_q;
    last_seen_d          = last_seen_q;
    dut_in_d             = dut_in_q;
    exp_d                = exp_q;
    cmp_valid_d          = cmp_valid_q;
    dut_cken_d           = dut_cken_q;
    vec_count_d          = vec_count_q;
    mismatch_count_d     = mismatch_count_q;
    first_mismatch_idx_d = first_mismatch_idx_q;
    underrun_count_d     = underrun_count_q;

    if (fifo_push && in_last) last_seen_d = 1'b1;

    // vec_count_q already includes the record under compare, hence the -1.
    if (mism) begin
      mismatch_count_d = sat_inc16(mismatch_count_q);
      if (first_mismatch_idx_q == IDX_NONE) first_mismatch_idx_d = vec_count_q - 32'd1;
    end

    case (state_q)
      ST_PREFILL: begin
        dut_cken_d  = 1'b0;
        cmp_valid_d = 1'b0;
        if (fifo_count >= PREFILL_CNT) begin
          state_d = ST_RUN;
        end else if (last_seen_q) begin
          // A session whose last record is already buffered starts early;
          // an empty buffer with last_seen cannot occur but ends cleanly.
          state_d = fifo_empty ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop_now) begin
          state_d     = ST_FAIL;
          dut_cken_d  = 1'b0;
          cmp_valid_d = 1'b0;
        end else if (!fifo_empty) begin
          dut_in_d    = fifo_rdata[REC_W-1:OUT_W];
          exp_d       = fifo_rdata[OUT_W-1:0];
          cmp_valid_d = 1'b1;
          dut_cken_d  = 1'b1;
          vec_count_d = vec_count_q + 32'd1;
        end else if (last_seen_q) begin
          // The last record's compare (if pending) completes this cycle.
          state_d     = ST_DONE;
          dut_cken_d  = 1'b0;
          cmp_valid_d = 1'b0;
        end else begin
          // Underrun: freeze the core with dut_in held.
          dut_cken_d       = 1'b0;
          cmp_valid_d      = 1'b0;
          underrun_count_d = sat_inc16(underrun_count_q);
        end
      end

      default: begin
        // IDLE, DONE and FAIL all wait for a new session.
        dut_cken_d  = 1'b0;
        cmp_valid_d = 1'b0;
        if (start_ok) begin
          state_d              = ST_PREFILL;
          last_seen_d          = 1'b0;
          vec_count_d          = '0;
          mismatch_count_d     = '0;
          first_mismatch_idx_d = IDX_NONE;
          underrun_count_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= ST_IDLE;
      last_seen_q          <= 1'b0;
      dut_in_q             <= '0;
      exp_q                <= '0;
      cmp_valid_q          <= 1'b0;
      dut_cken_q           <= 1'b0;
      vec_count_q          <= '0;
      mismatch_count_q     <= '0;
      first_mismatch_idx_q <= IDX_NONE;
      underrun_count_q     <= '0;
    end else begin
      state_q              <= state_d;
      last_seen_q          <= last_seen_d;
      dut_in_q             <= dut_in_d;
      exp_q                <= exp_d;
      cmp_valid_q          <= cmp_valid_d;
      dut_cken_q           <= dut_cken_d;
      vec_count_q          <= vec_count_d;
      mismatch_count_q     <= mismatch_count_d;
      first_mismatch_idx_q <= first_mismatch_idx_d;
      underrun_count_q     <= underrun_count_d;
    end
  end

  assign dut_in             = dut_in_q;
  assign dut_cken           = dut_cken_q;
  assign busy               = busy_w;
  assign done               = (state_q == ST_DONE);
  assign fail               = (state_q == ST_FAIL);
  assign vec_count          = vec_count_q;
  assign mismatch_count     = mismatch_count_q;
  assign first_mismatch_idx = first_mismatch_idx_q;
  assign underrun_count     = underrun_count_q;

endmodule
`default_nettype wire
